if_id_redirect: RTL and testbench
=================================

# if_id_redirect

IF/ID pipeline register and control-flow resolver for the five-stage core. Latches the instruction word and its PC each cycle from the fetch stage, then decodes J, JAL, JR, BEQ and BNE in decode. Drives the branch and jump redirect inputs of the fetch stage (`branch_address`, `branch_ctrl`, `jump_address`, `jump_ctrl`) and squashes the one wrong-path instruction fetched behind a taken redirect. It is the consumer and return path of the fetch stage's instr/pc interface.

## Interface
- `CNT_W`, 16, width of the saturating taken-redirect counter
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `instr` input 32: instruction word from fetch, aligned with `pc`
- `pc` input 32: address of `instr`
- `flush` input 1: external squash of decode contents (exception/trap path)
- `rs_data` input 32: register-file read of `id_instr[25:21]`, combinational, same cycle
- `rt_data` input 32: register-file read of `id_instr[20:16]`, combinational, same cycle
- `id_instr` output 32: latched instruction
- `id_pc` output 32: latched PC
- `id_valid` output 1: latched instruction is architecturally live
- `branch_address` output 32: taken-branch target
- `branch_ctrl` output 1: select `branch_address` as next PC
- `jump_address` output 32: jump target
- `jump_ctrl` output 1: select `jump_address` as next PC
- `link_valid` output 1: JAL in decode, write `link_addr` to r31
- `link_addr` output 32: `id_pc + 4`
- `redirect_cnt` output `CNT_W`: number of taken redirects since reset, saturating

## Operation
- Pipeline register, updated every rising edge:
  - `id_instr <= instr`
  - `id_pc <= pc`
  - `id_valid <= ~(redirect | flush)`, where `redirect = branch_ctrl | jump_ctrl`.
- Squash FSM with two states:
  - RUN → SQUASH when `redirect & ~flush`.
  - SQUASH → RUN unconditionally after one cycle.
  - `flush` in either state → RUN, with `id_valid` = 0.
  - In SQUASH, `id_valid` = 0 and every redirect and link output is 0.
- Decode, active only when `id_valid` = 1 and state = RUN. Opcode is `id_instr[31:26]`; funct is `id_instr[5:0]`.
  - 0x02 J: `jump_ctrl` = 1; `jump_address = {pc4[31:28], id_instr[25:0], 2'b00}`, where `pc4 = id_pc + 4`.
  - 0x03 JAL: same as J; additionally `link_valid` = 1.
  - opcode 0x00, funct 0x08 JR: `jump_ctrl` = 1; `jump_address = rs_data`. No alignment check.
  - 0x04 BEQ: `branch_ctrl = (rs_data == rt_data)`.
  - 0x05 BNE: `branch_ctrl = (rs_data != rt_data)`.
  - Branch target: `branch_address = pc4 + (sext32(id_instr[15:0]) << 2)`. Modulo-2^32, wrap-around permitted, no fault.
- `branch_ctrl` and `jump_ctrl` are never both 1.
- `branch_address` and `jump_address` are computed unconditionally and are don't-care when their ctrl is 0.
- All other opcodes produce no redirect.
- `redirect_cnt` increments on each edge where `redirect` = 1 and `flush` = 0. It holds at all-ones once it saturates.
- `flush` has priority over a same-cycle redirect: no SQUASH entry and no count. The redirect outputs remain combinationally asserted for that cycle; the trap path overrides PC upstream.

## Timing
- Reset, evaluated at the edge:
  - `id_instr` = 0, `id_pc` = 0, `id_valid` = 0, state = RUN, `redirect_cnt` = 0.
  - All redirect and link outputs are 0.
- `rst` mid-SQUASH returns to RUN at the reset edge.
- Decode and redirect outputs are combinational from the registered state plus `rs_data`/`rt_data`.
  - Fetch takes the new PC at the next edge.
  - Branch penalty is exactly 1 bubble.
- Cycle N: branch in decode with `redirect` = 1, while fetch presents the sequential address `id_pc + 4`.
  - Edge N+1: that instruction is latched with `id_valid` = 0 (SQUASH), and fetch PC becomes the target.
  - Edge N+2: the target instruction is latched with `id_valid` = 1 (RUN).
- Back-to-back redirects are impossible because a redirect is never asserted in SQUASH.
- Latency from instr/pc input to `id_*` outputs: 1 cycle.

## Test plan
- Reset then sequential fetch: hold `rst` 2 cycles, then feed pc 0x0, 0x4, 0x8 with ADD words. Required: `id_valid` = 0 during reset; `id_pc` = 0x0 one cycle after deassert with `id_valid` = 1; no ctrl asserted; `redirect_cnt` = 0.
- Taken BEQ: `id_pc` = 0x100, imm = 0xFFFC, `rs_data` = `rt_data` = 5. Required: `branch_ctrl` = 1, `branch_address` = 0xF4. Next cycle `id_pc` = 0x104 with `id_valid` = 0; cycle after, `id_pc` = 0xF4 with `id_valid` = 1; `redirect_cnt` = 1.
- Not-taken BNE: `rs_data` = `rt_data` = 7. Required: `branch_ctrl` = 0, no bubble, count unchanged.
- JAL and JR:
  - JAL at 0x3000_0010, target field 0x0000040. Required: `jump_address` = 0x3000_0100, `link_valid` = 1, `link_addr` = 0x3000_0014.
  - JR with `rs_data` = 0x0000_0ABC. Required: `jump_address` = 0xABC.
- Branch directly behind branch: taken BEQ followed by a fetched BNE that would be taken. Required: the BNE is squashed with no `branch_ctrl` in SQUASH, and only one count increment.
- Flush and saturation:
  - `flush` with a taken J in decode. Required: next cycle `id_valid` = 0, state RUN, count unchanged.
  - `CNT_W` = 2 with 5 taken jumps. Required: `redirect_cnt` = 3.

Source files
------------

// File: rtl/if_id_redirect.sv
// IF/ID pipeline register with decode-stage resolution of J/JAL/JR/BEQ/BNE.
// Drives the fetch redirect inputs and squashes the one wrong-path instruction behind a taken redirect.
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | decode live; redirects resolved from the latched instruction
// SQUASH | latched instruction is wrong-path; all redirect/link outputs held 0
module if_id_redirect #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic [31:0]      pc,
    input  logic             flush,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      rt_data,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic [31:0]      branch_address,
    output logic             branch_ctrl,
    output logic [31:0]      jump_address,
    output logic             jump_ctrl,
    output logic             link_valid,
    output logic [31:0]      link_addr,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        redirect;
    logic        decode_en;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc4;
    logic [31:0] br_offset;
    logic        is_jr;
    logic        cnt_sat;

    assign opcode    = id_instr[31:26];
    assign funct     = id_instr[5:0];
    assign pc4       = id_pc + 32'd4;
    assign br_offset = {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
    assign is_jr     = (opcode == OP_SPECIAL) && (funct == FN_JR);
    assign decode_en = id_valid && (state == RUN);
    assign redirect  = branch_ctrl | jump_ctrl;
    assign cnt_sat   = &redirect_cnt;

    // Targets are formed regardless of opcode; the ctrl bits qualify them.
    assign branch_address = pc4 + br_offset;
    assign jump_address   = is_jr ? rs_data : {pc4[31:28], id_instr[25:0], 2'b00};
    assign link_addr      = pc4;

    always_comb begin
        branch_ctrl = 1'b0;
        jump_ctrl   = 1'b0;
        link_valid  = 1'b0;
        if (decode_en) begin
            case (opcode)
                OP_J:       jump_ctrl = 1'b1;
                OP_JAL: begin
                    jump_ctrl  = 1'b1;
                    link_valid = 1'b1;
                end
                OP_SPECIAL: jump_ctrl = is_jr;
                OP_BEQ:     branch_ctrl = (rs_data == rt_data);
                OP_BNE:     branch_ctrl = (rs_data != rt_data);
                default: begin
                    branch_ctrl = 1'b0;
                    jump_ctrl   = 1'b0;
                end
            endcase
        end
    end

    // Flush wins over a same-cycle redirect: no squash entry.
    always_comb begin
        state_nx = state;
        case (state)
            RUN:     state_nx = (redirect && !flush) ? SQUASH : RUN;
            SQUASH:  state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_instr     <= '0;
            id_pc        <= '0;
            id_valid     <= 1'b0;
            state        <= RUN;
            redirect_cnt <= '0;
        end else begin
            id_instr <= instr;
            id_pc    <= pc;
            id_valid <= ~(redirect | flush);
            state    <= state_nx;
            if (redirect && !flush && !cnt_sat)
                redirect_cnt <= redirect_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_id_redirect.sv
// Directed bench for if_id_redirect; a second instance with CNT_W=2 shares the stimulus
// so its counter saturation can be compared against the full-width count.
module tb_if_id_redirect;

    localparam logic [31:0] ADD   = 32'h0022_0820;
    localparam logic [31:0] BEQ_M = 32'h1022_FFFC;
    localparam logic [31:0] BNE_M = 32'h1422_FFFC;
    localparam logic [31:0] BNE_F = 32'h1422_0003;
    localparam logic [31:0] JAL_I = 32'h0C00_0040;
    localparam logic [31:0] JR_I  = 32'h0060_0008;
    localparam logic [31:0] J_I   = 32'h0800_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr, pc, rs_data, rt_data;
    logic        flush;

    logic [31:0] id_instr, id_pc, branch_address, jump_address, link_addr;
    logic        id_valid, branch_ctrl, jump_ctrl, link_valid;
    logic [15:0] redirect_cnt;

    logic [31:0] s_id_instr, s_id_pc, s_branch_address, s_jump_address, s_link_addr;
    logic        s_id_valid, s_branch_ctrl, s_jump_ctrl, s_link_valid;
    logic [1:0]  s_redirect_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_redirect #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .branch_address(branch_address), .branch_ctrl(branch_ctrl),
        .jump_address(jump_address), .jump_ctrl(jump_ctrl),
        .link_valid(link_valid), .link_addr(link_addr), .redirect_cnt(redirect_cnt)
    );

    if_id_redirect #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .instr(instr), .pc(pc), .flush(flush),
        .rs_data(rs_data), .rt_data(rt_data),
        .id_instr(s_id_instr), .id_pc(s_id_pc), .id_valid(s_id_valid),
        .branch_address(s_branch_address), .branch_ctrl(s_branch_ctrl),
        .jump_address(s_jump_address), .jump_ctrl(s_jump_ctrl),
        .link_valid(s_link_valid), .link_addr(s_link_addr), .redirect_cnt(s_redirect_cnt)
    );

    task automatic present(input logic [31:0] i, input logic [31:0] p);
        instr = i;
        pc    = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rs_data = 0; rt_data = 0;
        present(ADD, 32'h0);
        tick(); tick();
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
        checks++; if ({branch_ctrl, jump_ctrl, link_valid} !== 3'b000) begin errors++; $display("FAIL rst_ctrl: got %b want 000", {branch_ctrl, jump_ctrl, link_valid}); end
        checks++; if (redirect_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", redirect_cnt); end
        rst = 1'b0;
        present(ADD, 32'h0);
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'h0, 1'b1}) begin errors++; $display("FAIL seq0: got pc=%h v=%b want pc=0 v=1", id_pc, id_valid); end
        present(ADD, 32'h4);
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'h4, 1'b1}) begin errors++; $display("FAIL seq4: got pc=%h v=%b want pc=4 v=1", id_pc, id_valid); end
        present(ADD, 32'h8);
        tick(); #1;
        checks++; if ({id_pc, id_instr, branch_ctrl, jump_ctrl} !== {32'h8, ADD, 2'b00}) begin errors++; $display("FAIL seq8: got pc=%h i=%h b=%b j=%b want pc=8 add no ctrl", id_pc, id_instr, branch_ctrl, jump_ctrl); end
        checks++; if (redirect_cnt !== 16'd0) begin errors++; $display("FAIL seq_cnt: got %0d want 0", redirect_cnt); end
    endtask

    task automatic test_taken_beq();
        present(BEQ_M, 32'h100);
        tick();
        rs_data = 5; rt_data = 5;
        present(ADD, 32'h104);
        #1;
        checks++; if ({branch_ctrl, jump_ctrl} !== 2'b10) begin errors++; $display("FAIL beq_ctrl: got b=%b j=%b want b=1 j=0", branch_ctrl, jump_ctrl); end
        checks++; if (branch_address !== 32'hF4) begin errors++; $display("FAIL beq_addr: got %h want 000000f4", branch_address); end
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'h104, 1'b0}) begin errors++; $display("FAIL beq_squash: got pc=%h v=%b want pc=104 v=0", id_pc, id_valid); end
        checks++; if (branch_ctrl !== 1'b0) begin errors++; $display("FAIL beq_squash_ctrl: got %b want 0", branch_ctrl); end
        checks++; if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL beq_cnt: got %0d want 1", redirect_cnt); end
        present(ADD, 32'hF4);
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'hF4, 1'b1}) begin errors++; $display("FAIL beq_target: got pc=%h v=%b want pc=f4 v=1", id_pc, id_valid); end
    endtask

    task automatic test_not_taken_bne();
        present(BNE_F, 32'h200);
        tick();
        rs_data = 7; rt_data = 7;
        present(ADD, 32'h204);
        #1;
        checks++; if (branch_ctrl !== 1'b0) begin errors++; $display("FAIL bne_nt_ctrl: got %b want 0", branch_ctrl); end
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'h204, 1'b1}) begin errors++; $display("FAIL bne_nt_nobubble: got pc=%h v=%b want pc=204 v=1", id_pc, id_valid); end
        checks++; if (redirect_cnt !== 16'd1) begin errors++; $display("FAIL bne_nt_cnt: got %0d want 1", redirect_cnt); end
    endtask

    task automatic test_jal_jr();
        present(JAL_I, 32'h3000_0010);
        tick();
        present(ADD, 32'h3000_0014);
        #1;
        checks++; if ({jump_ctrl, branch_ctrl, link_valid} !== 3'b101) begin errors++; $display("FAIL jal_ctrl: got j=%b b=%b l=%b want 1 0 1", jump_ctrl, branch_ctrl, link_valid); end
        checks++; if (jump_address !== 32'h3000_0100) begin errors++; $display("FAIL jal_addr: got %h want 30000100", jump_address); end
        checks++; if (link_addr !== 32'h3000_0014) begin errors++; $display("FAIL jal_link: got %h want 30000014", link_addr); end
        tick(); #1;
        checks++; if ({id_valid, link_valid, jump_ctrl} !== 3'b000) begin errors++; $display("FAIL jal_squash: got v=%b l=%b j=%b want 000", id_valid, link_valid, jump_ctrl); end
        checks++; if (redirect_cnt !== 16'd2) begin errors++; $display("FAIL jal_cnt: got %0d want 2", redirect_cnt); end
        present(JR_I, 32'h3000_0100);
        tick();
        rs_data = 32'h0000_0ABC;
        present(ADD, 32'h3000_0104);
        #1;
        checks++; if ({jump_ctrl, link_valid} !== 2'b10) begin errors++; $display("FAIL jr_ctrl: got j=%b l=%b want 1 0", jump_ctrl, link_valid); end
        checks++; if (jump_address !== 32'hABC) begin errors++; $display("FAIL jr_addr: got %h want 00000abc", jump_address); end
        tick(); #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL jr_squash: got %b want 0", id_valid); end
        checks++; if ({redirect_cnt, s_redirect_cnt} !== {16'd3, 2'd3}) begin errors++; $display("FAIL jr_cnt: got %0d/%0d want 3/3", redirect_cnt, s_redirect_cnt); end
        present(ADD, 32'hABC);
        tick(); #1;
        checks++; if ({id_pc, id_valid} !== {32'hABC, 1'b1}) begin errors++; $display("FAIL jr_target: got pc=%h v=%b want abc 1", id_pc, id_valid); end
    endtask

    task automatic test_back_to_back();
        present(BEQ_M, 32'h400);
        tick();
        rs_data = 9; rt_data = 9;
        present(BNE_M, 32'h404);
        #1;
        checks++; if ({branch_ctrl, branch_address} !== {1'b1, 32'h3F4}) begin errors++; $display("FAIL b2b_beq: got b=%b a=%h want 1 3f4", branch_ctrl, branch_address); end
        tick();
        rs_data = 1; rt_data = 2;
        #1;
        checks++; if ({id_instr, id_valid, branch_ctrl} !== {BNE_M, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_bne_squash: got i=%h v=%b b=%b want bne 0 0", id_instr, id_valid, branch_ctrl); end
        checks++; if ({redirect_cnt, s_redirect_cnt} !== {16'd4, 2'd3}) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d want 4/3", redirect_cnt, s_redirect_cnt); end
        present(ADD, 32'h3F4);
        tick(); #1;
        checks++; if ({id_pc, id_valid, branch_ctrl} !== {32'h3F4, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_target: got pc=%h v=%b b=%b want 3f4 1 0", id_pc, id_valid, branch_ctrl); end
        checks++; if (redirect_cnt !== 16'd4) begin errors++; $display("FAIL b2b_cnt_hold: got %0d want 4", redirect_cnt); end
    endtask

    task automatic test_flush();
        present(J_I, 32'h500);
        tick();
        present(ADD, 32'h504);
        flush = 1'b1;
        #1;
        checks++; if ({jump_ctrl, jump_address} !== {1'b1, 32'h400}) begin errors++; $display("FAIL flush_j_comb: got j=%b a=%h want 1 400", jump_ctrl, jump_address); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({id_valid, jump_ctrl} !== 2'b00) begin errors++; $display("FAIL flush_valid: got v=%b j=%b want 00", id_valid, jump_ctrl); end
        checks++; if (redirect_cnt !== 16'd4) begin errors++; $display("FAIL flush_cnt: got %0d want 4", redirect_cnt); end
        present(J_I, 32'h508);
        tick(); #1;
        checks++; if ({id_valid, jump_ctrl} !== 2'b11) begin errors++; $display("FAIL flush_run: got v=%b j=%b want 11", id_valid, jump_ctrl); end
        present(ADD, 32'h50C);
        tick(); #1;
        checks++; if ({redirect_cnt, s_redirect_cnt} !== {16'd5, 2'd3}) begin errors++; $display("FAIL flush_after_cnt: got %0d/%0d want 5/3", redirect_cnt, s_redirect_cnt); end
    endtask

    task automatic test_rst_in_squash();
        present(J_I, 32'h700);
        tick();
        present(ADD, 32'h704);
        tick();
        rst = 1'b1;
        tick(); #1;
        checks++; if ({id_valid, id_pc, jump_ctrl, redirect_cnt} !== {1'b0, 32'h0, 1'b0, 16'd0}) begin errors++; $display("FAIL rst_squash: got v=%b pc=%h j=%b c=%0d want 0 0 0 0", id_valid, id_pc, jump_ctrl, redirect_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] base;
        for (int k = 0; k < 5; k++) begin
            base = 32'h800 + 32'(k * 8);
            present(J_I, base);
            tick(); #1;
            checks++; if ({id_valid, jump_ctrl, s_jump_ctrl} !== 3'b111) begin errors++; $display("FAIL sat_j%0d: got v=%b j=%b sj=%b want 111", k, id_valid, jump_ctrl, s_jump_ctrl); end
            present(ADD, base + 32'd4);
            tick(); #1;
            checks++; if ({redirect_cnt, s_redirect_cnt} !== {16'(k + 1), (k >= 2) ? 2'd3 : 2'(k + 1)}) begin errors++; $display("FAIL sat_cnt%0d: got %0d/%0d want %0d/%0d", k, redirect_cnt, s_redirect_cnt, k + 1, (k >= 2) ? 3 : k + 1); end
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_taken_beq();
        test_not_taken_bne();
        test_jal_jr();
        test_back_to_back();
        test_flush();
        test_rst_in_squash();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
